// File: rtl/cpu_mem_responder.sv
// cpu_mem_responder
//   Memory-side responder for the multi-cycle CPU handshake interfaces. Owns a
//   single word-addressed RAM and answers instruction fetches and data
//   loads/stores with a configurable request-to-ack delay and ack-to-response
//   delay. Data requests win over a simultaneous fetch.
//
//   Build option: RANDOM_DELAY_EN -- when defined, every delay-counter load
//   takes lfsr[2:0] (0..7) from a 16-bit Fibonacci LFSR instead of the
//   REQ_DELAY/RESP_DELAY parameters.
//
// Parameters
//   ADDR_WIDTH  log2 of RAM depth in 32-bit words (word index = addr[ADDR_WIDTH+1:2])
//   REQ_DELAY   idle cycles between sampling a request and its ready/ack (0..15)
//   RESP_DELAY  idle cycles between a read handshake and response valid (0..15)
//
// Ports
//   clk, rst                         clock, synchronous active-high reset
//   PC, Inst_Req_Valid/Ready         fetch request channel
//   Instruction, Inst_Valid/Ready    fetch response channel
//   Address, MemWrite, Write_data,
//   Write_strb, MemRead, Mem_Req_Ack load/store request channel
//   Read_data, Read_data_Valid/Ready load response channel
module cpu_mem_responder #(
    parameter int ADDR_WIDTH = 12,
    parameter int REQ_DELAY  = 2,
    parameter int RESP_DELAY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PC,
    input  logic        Inst_Req_Valid,
    output logic        Inst_Req_Ready,
    output logic [31:0] Instruction,
    output logic        Inst_Valid,
    input  logic        Inst_Ready,
    input  logic [31:0] Address,
    input  logic        MemWrite,
    input  logic [31:0] Write_data,
    input  logic [3:0]  Write_strb,
    input  logic        MemRead,
    output logic        Mem_Req_Ack,
    output logic [31:0] Read_data,
    output logic        Read_data_Valid,
    input  logic        Read_data_Ready
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [2:0] {
        IDLE, I_WAIT, I_ACK, I_RESP, D_WAIT, D_ACK, D_RESP
    } state_t;

    state_t          state;
    logic [3:0]      cnt;
    logic [31:0]     ram [DEPTH];
    logic [ADDR_WIDTH-1:0] pc_idx, d_idx;
    logic [3:0]      req_dly, rsp_dly;

    // Out-of-range address bits are intentionally dropped (addresses wrap).
    assign pc_idx = PC[ADDR_WIDTH+1:2];
    assign d_idx  = Address[ADDR_WIDTH+1:2];

    wire unused_addr_bits = ^{PC[31:ADDR_WIDTH+2], PC[1:0],
                              Address[31:ADDR_WIDTH+2], Address[1:0]};

`ifdef RANDOM_DELAY_EN
    logic [15:0] lfsr;

    // Fibonacci LFSR, taps 16,14,13,11; free-running every cycle.
    always_ff @(posedge clk) begin
        if (rst) lfsr <= 16'hACE1;
        else     lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    assign req_dly = {1'b0, lfsr[2:0]};
    assign rsp_dly = {1'b0, lfsr[2:0]};
`else
    assign req_dly = 4'(REQ_DELAY);
    assign rsp_dly = 4'(RESP_DELAY);
`endif

    // Store commits on the edge that ends the ack cycle; MemWrite wins over
    // MemRead. Reset suppresses the write so an abandoned store leaves RAM alone.
    always_ff @(posedge clk) begin
        if (!rst && state == D_ACK && MemWrite) begin
            for (int i = 0; i < 4; i++)
                if (Write_strb[i]) ram[d_idx][8*i +: 8] <= Write_data[8*i +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            cnt             <= 4'd0;
            Inst_Req_Ready  <= 1'b0;
            Instruction     <= 32'h0;
            Inst_Valid      <= 1'b0;
            Mem_Req_Ack     <= 1'b0;
            Read_data       <= 32'h0;
            Read_data_Valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (MemRead || MemWrite) begin
                        state <= D_WAIT;
                        cnt   <= req_dly;
                    end else if (Inst_Req_Valid) begin
                        state <= I_WAIT;
                        cnt   <= req_dly;
                    end
                end

                // Counter hits zero one edge before the ack cycle, so the ack
                // appears REQ_DELAY+1 cycles after the request was sampled.
                I_WAIT: begin
                    if (!Inst_Req_Valid) begin
                        state <= IDLE;
                    end else if (cnt == 4'd0) begin
                        state          <= I_ACK;
                        Inst_Req_Ready <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end

                // A zero response delay raises valid straight out of the ack cycle.
                I_ACK: begin
                    Inst_Req_Ready <= 1'b0;
                    Instruction    <= ram[pc_idx];
                    cnt            <= rsp_dly;
                    Inst_Valid     <= (rsp_dly == 4'd0);
                    state          <= I_RESP;
                end

                I_RESP: begin
                    if (Inst_Valid) begin
                        if (Inst_Ready) begin
                            Inst_Valid <= 1'b0;
                            state      <= IDLE;
                        end
                    end else if (cnt <= 4'd1) begin
                        Inst_Valid <= 1'b1;
                        cnt        <= 4'd0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end

                D_WAIT: begin
                    if (!(MemRead || MemWrite)) begin
                        state <= IDLE;
                    end else if (cnt == 4'd0) begin
                        state       <= D_ACK;
                        Mem_Req_Ack <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end

                D_ACK: begin
                    Mem_Req_Ack <= 1'b0;
                    if (MemWrite) begin
                        state <= IDLE;
                    end else begin
                        Read_data       <= ram[d_idx];
                        cnt             <= rsp_dly;
                        Read_data_Valid <= (rsp_dly == 4'd0);
                        state           <= D_RESP;
                    end
                end

                D_RESP: begin
                    if (Read_data_Valid) begin
                        if (Read_data_Ready) begin
                            Read_data_Valid <= 1'b0;
                            state           <= IDLE;
                        end
                    end else if (cnt <= 4'd1) begin
                        Read_data_Valid <= 1'b1;
                        cnt             <= 4'd0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
